// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared types, sizes and round-robin search for the 4-way arbiter
package mux4_rr_arbiter_pkg;

    localparam int N_REQ  = 4;
    localparam int DW     = 4;
    localparam int HOLD_W = 4;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // first requester found scanning start, start+1, ... modulo 4
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] start);
        logic [1:0] w;
        w = start;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[start + 2'(i)]) w = start + 2'(i);
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input logic [1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// mux4_rr_arbiter_mux: behavioural 4:1 data select
module mux4_rr_arbiter_mux
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [DW-1:0] i0,
    input  logic [DW-1:0] i1,
    input  logic [DW-1:0] i2,
    input  logic [DW-1:0] i3,
    input  logic [1:0]    sel,
    output logic [DW-1:0] y
);

    // pick the word of the selected requester
    always_comb y = sel[1] ? (sel[0] ? i3 : i2) : (sel[0] ? i1 : i0);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin 4-requester arbiter with bounded hold and registered 4:1 datapath
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] Req,
    input  logic [DW-1:0]    I0,
    input  logic [DW-1:0]    I1,
    input  logic [DW-1:0]    I2,
    input  logic [DW-1:0]    I3,
    output logic [N_REQ-1:0] Gnt,
    output logic [1:0]       Sel,
    output logic [DW-1:0]    Data_out,
    output logic             Valid_out
);

    state_t            state, state_n;
    logic [1:0]        ptr, ptr_n, sel_n, nxt;
    logic [N_REQ-1:0]  gnt_n, others;
    logic [DW-1:0]     data_n, mux_y;
    logic [HOLD_W-1:0] hold, hold_n;
    logic              valid_n;

    mux4_rr_arbiter_mux u_mux (
        .i0 (I0),
        .i1 (I1),
        .i2 (I2),
        .i3 (I3),
        .sel(Sel),
        .y  (mux_y)
    );

    // arbitration decisions: grant from idle, transfer, rotate at hold limit, release
    always_comb begin
        state_n = state;
        gnt_n   = Gnt;
        sel_n   = Sel;
        data_n  = Data_out;
        valid_n = 1'b0;
        ptr_n   = ptr;
        hold_n  = hold;
        nxt     = Sel + 2'd1;
        others  = Req & ~Gnt;
        if (state == IDLE) begin
            if (|Req) begin
                sel_n   = rr_pick(Req, ptr);
                gnt_n   = to_onehot(sel_n);
                hold_n  = '0;
                state_n = BUSY;
            end
        end else if (Req[Sel]) begin
            data_n  = mux_y;
            valid_n = 1'b1;
            hold_n  = hold + HOLD_W'(1);
            if (hold_n == HOLD_W'(MAX_HOLD)) begin
                hold_n = '0;
                if (|others) begin
                    sel_n = rr_pick(others, nxt);
                    gnt_n = to_onehot(sel_n);
                    ptr_n = nxt;
                end
            end
        end else begin
            ptr_n  = nxt;
            hold_n = '0;
            if (|Req) begin
                sel_n = rr_pick(Req, nxt);
                gnt_n = to_onehot(sel_n);
            end else begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        end
    end

    // state, grant, pointer, hold counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            Gnt       <= '0;
            Sel       <= '0;
            Data_out  <= '0;
            Valid_out <= 1'b0;
            ptr       <= '0;
            hold      <= '0;
        end else begin
            state     <= state_n;
            Gnt       <= gnt_n;
            Sel       <= sel_n;
            Data_out  <= data_n;
            Valid_out <= valid_n;
            ptr       <= ptr_n;
            hold      <= hold_n;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed self-checking bench for the round-robin arbiter
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Req, I0, I1, I2, I3;
    logic [3:0] Gnt, Data_out;
    logic [1:0] Sel;
    logic       Valid_out;
    int         checks = 0;
    int         errors = 0;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .Req      (Req),
        .I0       (I0),
        .I1       (I1),
        .I2       (I2),
        .I3       (I3),
        .Gnt      (Gnt),
        .Sel      (Sel),
        .Data_out (Data_out),
        .Valid_out(Valid_out)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        Req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Req = 4'b1111;
        I0 = 4'h1; I1 = 4'h2; I2 = 4'h3; I3 = 4'h4;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({Gnt, Sel, Data_out, Valid_out} !== 11'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: gnt=%b sel=%0d data=%h valid=%b, want all zero", c, Gnt, Sel, Data_out, Valid_out);
            end
        end
        rst = 1'b0;
        Req = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        I2 = 4'hA;
        Req = 4'b0100;
        @(negedge clk);
        checks++;
        if (Gnt !== 4'b0100 || Sel !== 2'd2 || Valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: gnt=%b sel=%0d valid=%b, want 0100 2 0", Gnt, Sel, Valid_out);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (Valid_out !== 1'b1 || Data_out !== 4'hA || Gnt !== 4'b0100) begin
                errors++;
                $display("FAIL single_xfer%0d: valid=%b data=%h gnt=%b, want 1 a 0100", c, Valid_out, Data_out, Gnt);
            end
        end
        Req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Valid_out !== 1'b0 || Gnt !== 4'b0000 || Data_out !== 4'hA) begin
            errors++;
            $display("FAIL single_release: valid=%b gnt=%b data=%h, want 0 0000 a", Valid_out, Gnt, Data_out);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [3:0] exp_d;
        do_reset();
        I0 = 4'h1; I1 = 4'h2; I2 = 4'h3; I3 = 4'h4;
        Req = 4'b1111;
        @(negedge clk);
        checks++;
        if (Gnt !== 4'b0001 || Valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rot_first: gnt=%b valid=%b, want 0001 0", Gnt, Valid_out);
        end
        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < 4; t++) begin
                @(negedge clk);
                exp_d = 4'(k % 4 + 1);
                exp_g = (t < 3) ? 4'(1 << (k % 4)) : 4'(1 << ((k + 1) % 4));
                checks++;
                if (Valid_out !== 1'b1 || Data_out !== exp_d || Gnt !== exp_g) begin
                    errors++;
                    $display("FAIL rot_k%0d_t%0d: valid=%b data=%h gnt=%b, want 1 %h %b", k, t, Valid_out, Data_out, Gnt, exp_d, exp_g);
                end
            end
        end
        Req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Valid_out !== 1'b0 || Gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rot_idle: valid=%b gnt=%b, want 0 0000", Valid_out, Gnt);
        end
    endtask

    task automatic test_early_release_wrap();
        do_reset();
        I0 = 4'h5; I3 = 4'hC;
        Req = 4'b0001;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (Valid_out !== 1'b1 || Data_out !== 4'h5 || Gnt !== 4'b0001) begin
                errors++;
                $display("FAIL early_xfer%0d: valid=%b data=%h gnt=%b, want 1 5 0001", c, Valid_out, Data_out, Gnt);
            end
        end
        Req = 4'b1000;
        @(negedge clk);
        checks++;
        if (Gnt !== 4'b1000 || Sel !== 2'd3 || Valid_out !== 1'b0) begin
            errors++;
            $display("FAIL early_handoff: gnt=%b sel=%0d valid=%b, want 1000 3 0", Gnt, Sel, Valid_out);
        end
        @(negedge clk);
        checks++;
        if (Valid_out !== 1'b1 || Data_out !== 4'hC) begin
            errors++;
            $display("FAIL early_i3: valid=%b data=%h, want 1 c", Valid_out, Data_out);
        end
        Req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Gnt !== 4'b0000 || Valid_out !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: gnt=%b valid=%b, want 0000 0", Gnt, Valid_out);
        end
        Req = 4'b1001;
        @(negedge clk);
        checks++;
        if (Gnt !== 4'b0001 || Sel !== 2'd0) begin
            errors++;
            $display("FAIL wrap_winner: gnt=%b sel=%0d, want 0001 0", Gnt, Sel);
        end
        Req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        I0 = 4'h7; I1 = 4'h9;
        Req = 4'b0010;
        @(negedge clk);
        checks++;
        if (Gnt !== 4'b0010 || Sel !== 2'd1) begin
            errors++;
            $display("FAIL mid_grant: gnt=%b sel=%0d, want 0010 1", Gnt, Sel);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (Valid_out !== 1'b1 || Data_out !== 4'h9) begin
                errors++;
                $display("FAIL mid_xfer%0d: valid=%b data=%h, want 1 9", c, Valid_out, Data_out);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({Gnt, Sel, Data_out, Valid_out} !== 11'b0) begin
            errors++;
            $display("FAIL mid_reset: gnt=%b sel=%0d data=%h valid=%b, want all zero", Gnt, Sel, Data_out, Valid_out);
        end
        rst = 1'b0;
        Req = 4'b0011;
        @(negedge clk);
        checks++;
        if (Gnt !== 4'b0001 || Valid_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_grant: gnt=%b valid=%b, want 0001 0", Gnt, Valid_out);
        end
        @(negedge clk);
        checks++;
        if (Valid_out !== 1'b1 || Data_out !== 4'h7) begin
            errors++;
            $display("FAIL post_reset_xfer: valid=%b data=%h, want 1 7", Valid_out, Data_out);
        end
        Req = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        Req = 4'b0000;
        I0 = 4'h0; I1 = 4'h0; I2 = 4'h0; I3 = 4'h0;
        test_reset();
        test_single();
        test_rotation();
        test_early_release_wrap();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive transfers per grant when another requester is waiting; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: Req  input  4  Req[k] high = requester k wants the shared output.
REQ-005 Port: I0, I1, I2, I3  input  4 each  requester data words.
REQ-006 Port: Gnt  output  4  registered one-hot grant, or all-zero when idle.
REQ-007 Port: Sel  output  2  registered index of the granted requester, driving the 4:1 datapath select.
REQ-008 Port: Data_out  output  4  registered word transferred from the granted requester.
REQ-009 Port: Valid_out  output  1  registered; high for exactly the cycles in which Data_out holds a new transfer.

Function
REQ-010 The block SHALL implement two states: IDLE (Gnt = 0) and BUSY (Gnt one-hot, Sel = index of Gnt bit).
REQ-011 In IDLE with Req = 0, the block SHALL remain in IDLE, keep Gnt = 0, drive Valid_out <= 0 and hold Data_out and Sel.
REQ-012 In IDLE with Req != 0, the block SHALL select a winner at the edge by round-robin search from the priority pointer ptr (ptr, ptr+1, ... mod 4), load Gnt/Sel with the winner, clear the hold counter, and enter BUSY; no transfer occurs on this edge.
REQ-013 Transfer: at each edge in BUSY with Gnt[k]=1 and Req[k]=1, the block SHALL set Data_out <= Ik, Valid_out <= 1 and increment the hold counter (one-cycle latency, sample to output).
REQ-014 Release: at an edge in BUSY with Gnt[k]=1 and Req[k]=0, the block SHALL perform no transfer (Valid_out <= 0) and set ptr <= k+1 mod 4; if other Req bits are high, it SHALL grant the next winner on that same edge (no bubble cycle), otherwise it SHALL return to IDLE with Gnt = 0.
REQ-015 Rotation: on the edge completing the MAX_HOLD-th transfer of the current grant k, if any Req[j] (j != k) is high, the block SHALL move Gnt/Sel to the round-robin winner searching from k+1, clear the hold counter and set ptr <= k+1 mod 4; the transfer on that edge SHALL still complete.
REQ-016 If only the owner is requesting at MAX_HOLD, the block SHALL clear the hold counter and keep the grant (no starvation possible because the search then moves past k).
REQ-017 The priority pointer SHALL wrap 3 -> 0.
REQ-018 Gnt SHALL never have more than one bit set; Sel SHALL always equal the encoded Gnt while BUSY.
REQ-019 Req changes on non-granted lines SHALL affect only the next arbitration decision, never the current transfer.

Reset
REQ-020 While rst is high at an edge, the block SHALL set the state to IDLE, Gnt = 0, Sel = 0, Data_out = 0, Valid_out = 0, ptr = 0 and hold counter = 0, overriding any transfer or grant event on that edge.
REQ-021 Reset asserted mid-grant SHALL drop the grant with no further transfer; the first post-reset arbitration SHALL start from requester 0.

Structure
REQ-022 State encoding, requester count (4), data width (4) and the round-robin search function SHALL reside in a shared package.
REQ-023 The output datapath SHALL be the existing behavioural 4:1 mux instantiated as one sub-module, selected by Sel and feeding the Data_out register; the arbiter FSM, ptr and hold counter SHALL stay in this module.

Verification
REQ-024 Reset: rst high for 2 cycles with Req=4'b1111 -> Gnt=0, Sel=0, Data_out=0, Valid_out=0 throughout.
REQ-025 Single requester: Req=4'b0100, I2=4'hA for 6 cycles -> Gnt=4'b0100, Sel=2 one edge after Req; then Valid_out=1 and Data_out=4'hA for 6 consecutive cycles; Req drop -> IDLE, Valid_out=0 next cycle.
REQ-026 Rotation: Req=4'b1111 held, MAX_HOLD=4 -> grants 0,1,2,3,0 in order, each owning exactly 4 Valid_out cycles with no gap between owners.
REQ-027 Early release: Gnt=4'b0001, Req drops to 4'b1000 after 2 transfers -> Gnt=4'b1000 on that edge; next Valid_out carries I3.
REQ-028 Wrap and fairness: after requester 3 releases, Req=4'b1001 -> requester 0 wins (ptr wrapped to 0).
REQ-029 Reset mid-grant: rst pulsed during a 4-transfer burst from requester 1 -> Valid_out=0 next cycle; post-reset Req=4'b0011 -> requester 0 granted first.
